// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the button reader.
package btn_pkg;

  localparam int BTN_MAX = 8;

  // Debounced state of one button; rel is the 1->0 pulse.
  typedef struct packed {
    logic level;
    logic press;
    logic rel;
  } btn_event_t;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, run-length debouncer and press/release edge pulses.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_raw,
  output btn_event_t o_evt
);

  localparam int             CW    = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  C_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic           REL   = (ACTIVE_LOW != 0);

  logic          r_sync1, r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level, r_press, r_rel;
  logic          w_s;

  assign w_s = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= REL;
      r_sync2 <= REL;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_rel   <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      r_rel   <= 1'b0;
      if (w_s == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == C_MAX) begin
        // last disagreeing sample of the run: accept the new level
        r_level <= w_s;
        r_cnt   <= '0;
        r_press <= w_s;
        r_rel   <= ~w_s;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_evt.level = r_level;
  assign o_evt.press = r_press;
  assign o_evt.rel   = r_rel;

endmodule

// File: rtl/button_reader.sv
// Debounced button bank with toggles and a wrapping press counter.
// Optional long-press detection is built when BTN_LONGPRESS_EN is defined.
module button_reader
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int ACTIVE_LOW      = 1,
  parameter int LONG_CYCLES     = 12000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_toggle,
  output logic [7:0]         press_count,
  output logic [NUM_BTN-1:0] long_press
);

  logic [NUM_BTN-1:0] r_toggle;
  logic [7:0]         r_count;
  logic [7:0]         w_pop;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_event_t w_evt;
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .i_raw (btn_raw[g]),
      .o_evt (w_evt)
    );
    assign btn_level[g]   = w_evt.level;
    assign btn_press[g]   = w_evt.press;
    assign btn_release[g] = w_evt.rel;
  end

  // simultaneous presses all count
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_BTN; i++) w_pop = w_pop + {7'd0, btn_press[i]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_toggle <= '0;
      r_count  <= '0;
    end else begin
      r_toggle <= r_toggle ^ btn_press;
      r_count  <= r_count + w_pop;
    end
  end

  assign btn_toggle  = r_toggle;
  assign press_count = r_count;

`ifdef BTN_LONGPRESS_EN
  localparam int            LW     = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] L_FIRE = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] L_SAT  = LW'(LONG_CYCLES);

  logic [NUM_BTN-1:0][LW-1:0] r_hold;
  logic [NUM_BTN-1:0]         r_long;

  // hold counter parks one past the fire value so each hold pulses once
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
      r_long <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        r_long[i] <= btn_level[i] && (r_hold[i] == L_FIRE);
        if (!btn_level[i])         r_hold[i] <= '0;
        else if (r_hold[i] != L_SAT) r_hold[i] <= r_hold[i] + 1'b1;
      end
    end
  end

  assign long_press = r_long;
`else
  assign long_press = '0;
`endif

endmodule

// File: tb/tb_button_reader.sv
// Random + directed bench for button_reader against a cycle-level behavioural model.
module tb_button_reader;

  localparam int NB = 4;
  localparam int DC = 4;
  localparam int LC = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] raw = '1;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_toggle, long_press;
  logic [7:0]    press_count;

  button_reader #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1), .LONG_CYCLES(LC)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_toggle(btn_toggle), .press_count(press_count), .long_press(long_press)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: pin seen two edges late; level flips after DC consecutive disagreeing samples.
  bit [NB-1:0] m_p0, m_p1, m_lvl, m_prs, m_rel, m_tog, m_long;
  bit [7:0]    m_cnt;
  int          m_dis [NB];
  int          m_pt  [NB];
  int          cyc = 0;

  task automatic model_edge();
    bit [NB-1:0] s;
    cyc++;
    if (rst) begin
      m_p0 = '0; m_p1 = '0; m_lvl = '0; m_prs = '0; m_rel = '0;
      m_tog = '0; m_long = '0; m_cnt = '0;
      for (int i = 0; i < NB; i++) begin m_dis[i] = 0; m_pt[i] = -1; end
    end else begin
      s      = m_p1;
      m_tog  = m_tog ^ m_prs;
      m_cnt  = m_cnt + 8'($countones(m_prs));
      m_prs  = '0; m_rel = '0; m_long = '0;
      for (int i = 0; i < NB; i++) begin
`ifdef BTN_LONGPRESS_EN
        if (m_lvl[i] && m_pt[i] >= 0 && (cyc - m_pt[i]) == LC) m_long[i] = 1'b1;
`endif
        m_dis[i] = (s[i] != m_lvl[i]) ? m_dis[i] + 1 : 0;
        if (m_dis[i] == DC) begin
          m_lvl[i] = s[i];
          m_dis[i] = 0;
          if (s[i]) begin m_prs[i] = 1'b1; m_pt[i] = cyc; end
          else      begin m_rel[i] = 1'b1; m_pt[i] = -1;  end
        end
      end
      m_p1 = m_p0;
      m_p0 = ~raw;
    end
  endtask

  task automatic step(input bit r, input logic [NB-1:0] v);
    @(negedge clk);
    rst = r;
    raw = v;
    @(posedge clk);
    model_edge();
    #1;
    chk("level",   btn_level,   m_lvl);
    chk("press",   btn_press,   m_prs);
    chk("release", btn_release, m_rel);
    chk("toggle",  btn_toggle,  m_tog);
    chk("count",   press_count, m_cnt);
    chk("long",    long_press,  m_long);
  endtask

  initial begin
    logic [NB-1:0] acc;
    logic [7:0]    c0;
    logic [NB-1:0] v;
    int nlong, lat;

    for (int k = 0; k < 3; k++) step(1'b1, 4'hF);
    chk("rst_out", {btn_level, btn_press, btn_release, btn_toggle, long_press, press_count}, 0);
    acc = '0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 4'hF);
      acc |= btn_press | btn_release | long_press | btn_level;
    end
    chk("rst_quiet", acc, 0);

    // btn0 press: accepted on the 6th edge after the pin falls
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 4'hE);
      if (k == 5) chk("b0_early", btn_level, 4'b0000);
    end
    chk("b0_level", btn_level, 4'b0001);
    chk("b0_press", btn_press, 4'b0001);
    step(1'b0, 4'hE);
    chk("b0_count",  press_count, 8'd1);
    chk("b0_toggle", btn_toggle,  4'b0001);

    nlong = 0; lat = 0;
    for (int k = 1; k <= 30; k++) begin
      step(1'b0, 4'hE);
      if (long_press[0]) begin nlong++; lat = k + 1; end
    end
`ifdef BTN_LONGPRESS_EN
    chk("long_n",   nlong, 1);
    chk("long_lat", lat,   LC);
`else
    chk("long_n",   nlong, 0);
`endif
    for (int k = 0; k < 8; k++) step(1'b0, 4'hF);

    // 3-cycle glitch on btn1 must be rejected
    c0 = press_count; acc = '0;
    for (int k = 0; k < 3; k++) begin step(1'b0, 4'hD); acc |= btn_press | btn_release; end
    for (int k = 0; k < 10; k++) begin step(1'b0, 4'hF); acc |= btn_press | btn_release; end
    chk("glitch_lvl",   btn_level[1], 1'b0);
    chk("glitch_pulse", acc, 0);
    chk("glitch_cnt",   press_count, c0);

    // reset mid-debounce, then re-acceptance of a held button
    step(1'b0, 4'hE);
    step(1'b0, 4'hE);
    step(1'b1, 4'hE);
    chk("mid_rst", {btn_level, btn_press, btn_release, btn_toggle, long_press, press_count}, 0);
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 4'hE);
      if (k == 5) chk("rst_reacq_early", btn_level[0], 1'b0);
    end
    chk("rst_reacq_lvl",   btn_level[0], 1'b1);
    chk("rst_reacq_press", btn_press,    4'b0001);
    for (int k = 0; k < 8; k++) step(1'b0, 4'hF);

    // drive count to 254, then a double press wraps it to 0
    for (int n = 0; n < 300 && m_cnt != 8'd254; n++) begin
      for (int k = 0; k < 8; k++) step(1'b0, 4'hE);
      for (int k = 0; k < 8; k++) step(1'b0, 4'hF);
    end
    chk("pre_wrap", press_count, 8'd254);
    for (int k = 0; k < 6; k++) step(1'b0, 4'h3);
    chk("dual_press", btn_press, 4'b1100);
    step(1'b0, 4'h3);
    chk("wrap_cnt", press_count, 8'd0);
    for (int k = 0; k < 8; k++) step(1'b0, 4'hF);

    // random pin activity with occasional resets
    v = 4'hF;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 5) == 0) v[$urandom_range(0, NB-1)] ^= 1'b1;
      step($urandom_range(0, 499) == 0, v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
